rect_fill: RTL
==============

// Module: rect_fill
// PURPOSE
//  Parametrised successor to the full-screen filler: plots an axis-aligned rectangle (inclusive corners)
//  into the VGA framebuffer adapter, one pixel per cycle, raster order (x fastest).
//  Supports 4 colour modes and clips to the screen. Sits between the task controller and the VGA adapter.
//  The controller uses a start/done handshake.
// PARAMETERS
//  SCREEN_W  160  screen width in pixels
//  SCREEN_H  120  screen height in pixels
//  X_W       8    x coordinate width (must satisfy 2**X_W >= SCREEN_W)
//  Y_W       7    y coordinate width (must satisfy 2**Y_W >= SCREEN_H)
//  COLOUR_W  3    colour width
// PORTS
//  clk         in   1         clock
//  rst         in   1         synchronous active-high reset
//  start       in   1         request; sampled only in IDLE
//  x0,x1       in   X_W       rectangle left/right, inclusive
//  y0,y1       in   Y_W       rectangle top/bottom, inclusive
//  colour      in   COLOUR_W  base colour
//  mode        in   2         fill_mode_t: SOLID, XSTRIPE, YSTRIPE, CHECKER
//  busy        out  1         high in FILL/DONE
//  done        out  1         one-cycle completion pulse
//  vga_x       out  X_W       pixel x
//  vga_y       out  Y_W       pixel y
//  vga_colour  out  COLOUR_W  pixel colour
//  vga_plot    out  1         pixel valid
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset forces IDLE and drives
//    vga_x/vga_y/vga_colour/vga_plot/done/busy to 0 at the next edge, including mid-fill.
//    A mid-fill reset produces no done pulse.
//  - States: IDLE -> FILL -> DONE -> IDLE. IDLE on an empty rectangle -> DONE directly.
//  - Edge E0 (IDLE && start): latch corners, colour and mode. Clip: cx1=min(x1,SCREEN_W-1), cy1=min(y1,SCREEN_H-1).
//    Empty if x0>cx1 or y0>cy1.
//  - Non-empty: after E0 -> FILL, vga_x=x0, vga_y=y0, vga_plot=1. Each edge in FILL advances one pixel:
//    x++ until cx1, then x=x0 and y++. Outputs are registered.
//  - N=W*H pixels -> vga_plot high for exactly N consecutive cycles after E0.
//    The next edge then sets vga_plot=0, done=1, state DONE. The following edge clears done and returns to IDLE.
//  - Empty: after E0 -> DONE with done=1 and vga_plot=0 throughout.
//  - start is ignored while busy. Input changes after E0 are ignored. Back-to-back start in the cycle after done is accepted.
//  - Colour per pixel (x,y): SOLID=colour; XSTRIPE=colour^x[COLOUR_W-1:0]; YSTRIPE=colour^y[COLOUR_W-1:0];
//    CHECKER=(x[0]^y[0]) ? ~colour : colour.
//  - No wrap-around: coordinate counters never exceed the clipped bounds. SCREEN_W-1 must not overflow X_W.
//  - vga_x/vga_y hold their last values when vga_plot=0 outside reset.
// CONFIGURATION
//  RECT_FILL_READY_EN defined: adds input vga_ready (1). The pixel on vga_x/vga_y/vga_colour with vga_plot=1
//    holds until sampled with vga_ready=1, then advances; completion follows the last accepted pixel.
//  Undefined: no vga_ready port; the adapter always accepts; one pixel per cycle as above.
// STRUCTURE
//  - rect_fill_pkg: fill_mode_t enum (2b), state_t enum {IDLE,FILL,DONE}, default SCREEN_W/SCREEN_H localparams.
//  - Sub-module rect_fill_colour: combinational (x,y,colour,mode)->pixel colour, instantiated once.
//  - Counters and the FSM stay in rect_fill.
// TESTING
//  1. x0=0,y0=0,x1=159,y1=119,SOLID,colour=5 -> 19200 plot cycles, all colour 5; last pixel (159,119); done 1 cycle later.
//  2. (10,5)-(12,6),XSTRIPE,colour=0 -> pixels (10,5)(11,5)(12,5)(10,6)(11,6)(12,6);
//     colours 2,3,4,2,3,4; done once.
//  3. x0=20,x1=10 -> no vga_plot; done=1 on the cycle after E0; busy for 1 cycle.
//  4. (150,110)-(255,127) -> x stops at 159, y at 119; 100 pixels; CHECKER alternates colour/~colour.
//  5. rst asserted at pixel 50 of a fill -> next cycle all outputs 0, IDLE, no done. A new start then fills normally.
//  6. RECT_FILL_READY_EN: hold vga_ready=0 for 3 cycles on pixel 2 -> that pixel is stable;
//     pixel count and order are unchanged.

Source files
------------

// File: rtl/rect_fill_pkg.sv
// Shared types and screen defaults for the rectangle filler.
package rect_fill_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        XSTRIPE = 2'd1,
        YSTRIPE = 2'd2,
        CHECKER = 2'd3
    } fill_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_fill_colour.sv
// Per-pixel colour pattern generator; only the low colour-width coordinate bits matter.
module rect_fill_colour
    import rect_fill_pkg::*;
#(
    parameter int COLOUR_W = 3
) (
    input  logic [COLOUR_W-1:0] i_x,
    input  logic [COLOUR_W-1:0] i_y,
    input  logic [COLOUR_W-1:0] i_colour,
    input  fill_mode_t          i_mode,
    output logic [COLOUR_W-1:0] o_colour
);

    // Pattern selection by fill mode
    always_comb begin
        o_colour = i_colour;
        case (i_mode)
            SOLID:   o_colour = i_colour;
            XSTRIPE: o_colour = i_colour ^ i_x;
            YSTRIPE: o_colour = i_colour ^ i_y;
            CHECKER: o_colour = (i_x[0] ^ i_y[0]) ? ~i_colour : i_colour;
            default: o_colour = i_colour;
        endcase
    end

endmodule

// File: rtl/rect_fill.sv
// Clipped rectangle plotter feeding the VGA adapter one pixel per accepted cycle.
// Optional macro RECT_FILL_READY_EN adds i_vga_ready back-pressure from the adapter.
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [X_W-1:0]      i_x0,
    input  logic [X_W-1:0]      i_x1,
    input  logic [Y_W-1:0]      i_y0,
    input  logic [Y_W-1:0]      i_y1,
    input  logic [COLOUR_W-1:0] i_colour,
    input  logic [1:0]          i_mode,
`ifdef RECT_FILL_READY_EN
    input  logic                i_vga_ready,
`endif
    output logic                o_busy,
    output logic                o_done,
    output logic [X_W-1:0]      o_vga_x,
    output logic [Y_W-1:0]      o_vga_y,
    output logic [COLOUR_W-1:0] o_vga_colour,
    output logic                o_vga_plot
);

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    state_t              r_state;
    logic [X_W-1:0]      r_x0;
    logic [X_W-1:0]      r_cx1;
    logic [Y_W-1:0]      r_cy1;
    logic [COLOUR_W-1:0] r_colour;
    fill_mode_t          r_mode;
    logic [X_W-1:0]      r_vga_x;
    logic [Y_W-1:0]      r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_plot;
    logic                r_done;
    logic                r_busy;

    logic [X_W-1:0]      w_cx1;
    logic [Y_W-1:0]      w_cy1;
    logic                w_empty;
    logic                w_last_x;
    logic                w_last_y;
    logic                w_adv;
    logic [X_W-1:0]      w_nx;
    logic [Y_W-1:0]      w_ny;
    logic [COLOUR_W-1:0] w_ncol;
    fill_mode_t          w_nmode;
    logic [COLOUR_W-1:0] w_pix_colour;

    // Clip request against the screen and decide whether anything is drawn
    always_comb begin
        w_cx1   = (i_x1 > X_MAX) ? X_MAX : i_x1;
        w_cy1   = (i_y1 > Y_MAX) ? Y_MAX : i_y1;
        w_empty = (i_x0 > w_cx1) || (i_y0 > w_cy1);
    end

    // Raster position of the pixel to be presented after the next edge
    always_comb begin
        w_last_x = (r_vga_x == r_cx1);
        w_last_y = (r_vga_y == r_cy1);
`ifdef RECT_FILL_READY_EN
        w_adv    = i_vga_ready;
`else
        w_adv    = 1'b1;
`endif
        w_nx     = r_vga_x;
        w_ny     = r_vga_y;
        w_ncol   = r_colour;
        w_nmode  = r_mode;
        if (r_state == IDLE) begin
            w_nx    = i_x0;
            w_ny    = i_y0;
            w_ncol  = i_colour;
            w_nmode = fill_mode_t'(i_mode);
        end else if (w_last_x) begin
            w_nx    = r_x0;
            w_ny    = r_vga_y + 1'b1;
        end else begin
            w_nx    = r_vga_x + 1'b1;
            w_ny    = r_vga_y;
        end
    end

    // The colour is computed for the upcoming pixel so it registers alongside x/y
    rect_fill_colour #(
        .COLOUR_W (COLOUR_W)
    ) u_colour (
        .i_x      (w_nx[COLOUR_W-1:0]),
        .i_y      (w_ny[COLOUR_W-1:0]),
        .i_colour (w_ncol),
        .i_mode   (w_nmode),
        .o_colour (w_pix_colour)
    );

    // Control FSM with registered pixel and handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_x0         <= '0;
            r_cx1        <= '0;
            r_cy1        <= '0;
            r_colour     <= '0;
            r_mode       <= SOLID;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_x0     <= i_x0;
                        r_cx1    <= w_cx1;
                        r_cy1    <= w_cy1;
                        r_colour <= i_colour;
                        r_mode   <= fill_mode_t'(i_mode);
                        r_busy   <= 1'b1;
                        if (w_empty) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= FILL;
                            r_vga_x      <= w_nx;
                            r_vga_y      <= w_ny;
                            r_vga_colour <= w_pix_colour;
                            r_vga_plot   <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (w_adv) begin
                        if (w_last_x && w_last_y) begin
                            r_state    <= DONE;
                            r_vga_plot <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_vga_x      <= w_nx;
                            r_vga_y      <= w_ny;
                            r_vga_colour <= w_pix_colour;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_vga_plot <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_vga_x      = r_vga_x;
    assign o_vga_y      = r_vga_y;
    assign o_vga_colour = r_vga_colour;
    assign o_vga_plot   = r_vga_plot;

endmodule
